// File: rtl/vga_scan_gen_if.sv
// rtl/vga_scan_gen_if.sv - pixel request / DAC bundle between the VGA scan generator and its pixel source
interface vga_scan_gen_if;
  logic [7:0]  rgb_r_in;
  logic [7:0]  rgb_g_in;
  logic [7:0]  rgb_b_in;
  logic [9:0]  j;
  logic [9:0]  i;
  logic        printing;
  logic        frame_start;
  logic [15:0] frame_count;
  logic        vga_hs;
  logic        vga_vs;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        vga_blank_n;
  logic        vga_sync_n;

  modport master (
    input  rgb_r_in, rgb_g_in, rgb_b_in,
    output j, i, printing, frame_start, frame_count,
    output vga_hs, vga_vs, vga_r, vga_g, vga_b, vga_blank_n, vga_sync_n
  );

  modport slave (
    output rgb_r_in, rgb_g_in, rgb_b_in,
    input  j, i, printing, frame_start, frame_count,
    input  vga_hs, vga_vs, vga_r, vga_g, vga_b, vga_blank_n, vga_sync_n
  );
endinterface

// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - VGA raster counters, pixel request stage and 2-clock aligned sync/blank/colour outputs
module vga_scan_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic           VGA_CLK,
  input  logic           reset,
  vga_scan_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [9:0]  j_q, j_d;
  logic [9:0]  i_q, i_d;
  logic        printing_q, printing_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_seen_q, frame_seen_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        hs_s0_q, hs_s0_d;
  logic        vs_s0_q, vs_s0_d;
  logic        hs_s1_q, hs_s1_d;
  logic        vs_s1_q, vs_s1_d;
  logic        print_s1_q, print_s1_d;
  logic        vga_hs_q, vga_hs_d;
  logic        vga_vs_q, vga_vs_d;
  logic        blank_n_q, blank_n_d;
  logic [7:0]  vga_r_q, vga_r_d;
  logic [7:0]  vga_g_q, vga_g_d;
  logic [7:0]  vga_b_q, vga_b_d;
  logic        visible;

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end

    visible    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    printing_d = visible;
    j_d        = visible ? h_cnt_q : '0;
    i_d        = visible ? v_cnt_q : '0;

    // The very first frame after reset is not a completed frame, so it only arms the counter.
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    frame_seen_d  = frame_seen_q | frame_start_d;
    frame_count_d = (frame_start_d && frame_seen_q) ? frame_count_q + 16'd1 : frame_count_q;

    hs_s0_d = (h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END);
    vs_s0_d = (v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END);

    hs_s1_d    = hs_s0_q;
    vs_s1_d    = vs_s0_q;
    print_s1_d = printing_q;

    // Colour arrives one clock after the request, so it lines up with the stage-1 blank here.
    vga_hs_d  = ~hs_s1_q;
    vga_vs_d  = ~vs_s1_q;
    blank_n_d = print_s1_q;
    vga_r_d   = print_s1_q ? bus.rgb_r_in : 8'h00;
    vga_g_d   = print_s1_q ? bus.rgb_g_in : 8'h00;
    vga_b_d   = print_s1_q ? bus.rgb_b_in : 8'h00;
  end

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      j_q           <= '0;
      i_q           <= '0;
      printing_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_seen_q  <= 1'b0;
      frame_count_q <= '0;
      hs_s0_q       <= 1'b0;
      vs_s0_q       <= 1'b0;
      hs_s1_q       <= 1'b0;
      vs_s1_q       <= 1'b0;
      print_s1_q    <= 1'b0;
      vga_hs_q      <= 1'b1;
      vga_vs_q      <= 1'b1;
      blank_n_q     <= 1'b0;
      vga_r_q       <= '0;
      vga_g_q       <= '0;
      vga_b_q       <= '0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      j_q           <= j_d;
      i_q           <= i_d;
      printing_q    <= printing_d;
      frame_start_q <= frame_start_d;
      frame_seen_q  <= frame_seen_d;
      frame_count_q <= frame_count_d;
      hs_s0_q       <= hs_s0_d;
      vs_s0_q       <= vs_s0_d;
      hs_s1_q       <= hs_s1_d;
      vs_s1_q       <= vs_s1_d;
      print_s1_q    <= print_s1_d;
      vga_hs_q      <= vga_hs_d;
      vga_vs_q      <= vga_vs_d;
      blank_n_q     <= blank_n_d;
      vga_r_q       <= vga_r_d;
      vga_g_q       <= vga_g_d;
      vga_b_q       <= vga_b_d;
    end
  end

  assign bus.j           = j_q;
  assign bus.i           = i_q;
  assign bus.printing    = printing_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_count = frame_count_q;
  assign bus.vga_hs      = vga_hs_q;
  assign bus.vga_vs      = vga_vs_q;
  assign bus.vga_blank_n = blank_n_q;
  assign bus.vga_r       = vga_r_q;
  assign bus.vga_g       = vga_g_q;
  assign bus.vga_b       = vga_b_q;
  assign bus.vga_sync_n  = 1'b0;
endmodule

// File: tb/tb_vga_scan_gen.sv
// tb/tb_vga_scan_gen.sv - self-checking bench for vga_scan_gen on a shrunken raster
module tb_vga_scan_gen;
  localparam int HA = 40, HF = 4, HS = 8, HB = 6;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic VGA_CLK = 1'b0;
  logic reset   = 1'b1;

  vga_scan_gen_if bus ();

  vga_scan_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .VGA_CLK (VGA_CLK),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  int checks   = 0;
  int failures = 0;
  int n        = 0;
  int fc_base  = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t n=%0d)", name, act, exp, $time, n);
    end
  endtask

  // n = clock edges since reset release; edge n presents raster position n-1 at stage 0.
  always @(posedge VGA_CLK or posedge reset) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  // Pixel source: registers {j, i, AA} one clock after the request, drives FF while blanked.
  logic [7:0] pend_r, pend_g, pend_b;
  initial begin
    bus.rgb_r_in = 8'h00;
    bus.rgb_g_in = 8'h00;
    bus.rgb_b_in = 8'h00;
    forever begin
      @(negedge VGA_CLK);
      if (bus.printing === 1'b1) begin
        pend_r = bus.j[7:0];
        pend_g = bus.i[7:0];
        pend_b = 8'hAA;
      end else begin
        pend_r = 8'hFF;
        pend_g = 8'hFF;
        pend_b = 8'hFF;
      end
      @(posedge VGA_CLK);
      #1;
      bus.rgb_r_in = pend_r;
      bus.rgb_g_in = pend_g;
      bus.rgb_b_in = pend_b;
    end
  end

  // Raster model: every output derived from position arithmetic on n.
  int p0, h0, v0, p2, h2, v2, e_j, e_i, e_fc, e_r, e_g, e_b;
  bit e_pr, e_fs, e_hs, e_vs, e_bl, vis2, go;
  always @(negedge VGA_CLK) begin
    go = 1'b0;
    if (chk_en) begin
      if (reset) begin
        e_pr = 0; e_j = 0; e_i = 0; e_fs = 0; e_fc = 0;
        e_hs = 1; e_vs = 1; e_bl = 0; e_r = 0; e_g = 0; e_b = 0;
        go = 1'b1;
      end else if (n >= 1) begin
        p0   = (n - 1) % FT;
        h0   = p0 % HT;
        v0   = p0 / HT;
        e_pr = (h0 < HA) && (v0 < VA);
        e_j  = e_pr ? h0 : 0;
        e_i  = e_pr ? v0 : 0;
        e_fs = (p0 == 0);
        e_fc = (fc_base + (n - 1) / FT) & 32'hFFFF;
        if (n >= 3) begin
          p2   = (n - 3) % FT;
          h2   = p2 % HT;
          v2   = p2 / HT;
          vis2 = (h2 < HA) && (v2 < VA);
          e_hs = !((h2 >= HA + HF) && (h2 < HA + HF + HS));
          e_vs = !((v2 >= VA + VF) && (v2 < VA + VF + VS));
          e_bl = vis2;
          e_r  = vis2 ? (h2 % 256) : 0;
          e_g  = vis2 ? (v2 % 256) : 0;
          e_b  = vis2 ? 170 : 0;
        end else begin
          e_hs = 1; e_vs = 1; e_bl = 0; e_r = 0; e_g = 0; e_b = 0;
        end
        go = 1'b1;
      end
    end
    if (go) begin
      chk("printing", bus.printing, e_pr);
      chk("j", bus.j, e_j);
      chk("i", bus.i, e_i);
      chk("frame_start", bus.frame_start, e_fs);
      chk("frame_count", bus.frame_count, e_fc);
      chk("vga_hs", bus.vga_hs, e_hs);
      chk("vga_vs", bus.vga_vs, e_vs);
      chk("vga_blank_n", bus.vga_blank_n, e_bl);
      chk("vga_r", bus.vga_r, e_r);
      chk("vga_g", bus.vga_g, e_g);
      chk("vga_b", bus.vga_b, e_b);
      chk("vga_sync_n", bus.vga_sync_n, 0);
      if (bus.vga_hs === 1'b0 || bus.vga_vs === 1'b0)
        chk("blank_in_sync", bus.vga_blank_n, 0);
    end
  end

  int pr_fall = -1, pr_rise2 = -1, hs_fall = -1, hs_rise = -1;
  int vs_fall = -1, vs_rise = -1, fs1 = -1, fs2 = -1, fc_at_fs2 = -1;
  bit found;

  task automatic wait_pos(input int target, input string name);
    found = 1'b0;
    for (int c = 0; c < 2 * FT + 4 && !found; c++) begin
      @(negedge VGA_CLK);
      if (((n - 1) % FT) == target) found = 1'b1;
    end
    chk(name, found, 1);
  endtask

  initial begin
    repeat (2) @(posedge VGA_CLK);
    chk_en = 1'b1;
    repeat (3) @(negedge VGA_CLK);
    #2 reset = 1'b0;

    // Two frames of event capture, then hand-computed expectations for this raster.
    for (int c = 0; c < 2 * FT + 12; c++) begin
      @(negedge VGA_CLK);
      if (c == 0) begin
        chk("lit_first_fs", bus.frame_start, 1);
        chk("lit_first_pr", bus.printing, 1);
        chk("lit_first_j", bus.j, 0);
        chk("lit_first_fc", bus.frame_count, 0);
      end
      if (pr_fall < 0 && bus.printing === 1'b0) pr_fall = n;
      else if (pr_fall >= 0 && pr_rise2 < 0 && bus.printing === 1'b1) pr_rise2 = n;
      if (hs_fall < 0 && bus.vga_hs === 1'b0) hs_fall = n;
      else if (hs_fall >= 0 && hs_rise < 0 && bus.vga_hs === 1'b1) hs_rise = n;
      if (vs_fall < 0 && bus.vga_vs === 1'b0) vs_fall = n;
      else if (vs_fall >= 0 && vs_rise < 0 && bus.vga_vs === 1'b1) vs_rise = n;
      if (bus.frame_start === 1'b1) begin
        if (fs1 < 0) fs1 = n;
        else if (fs2 < 0) begin
          fs2 = n;
          fc_at_fs2 = bus.frame_count;
        end
      end
    end
    chk("lit_pr_high_len", pr_fall - 1, 40);
    chk("lit_pr_low_len", pr_rise2 - pr_fall, 18);
    chk("lit_hs_start", hs_fall - 1, 46);
    chk("lit_hs_len", hs_rise - hs_fall, 8);
    chk("lit_vs_start", vs_fall, 467);
    chk("lit_vs_len", vs_rise - vs_fall, 116);
    chk("lit_fs_spacing", fs2 - fs1, 754);
    chk("lit_fc_after_fs2", fc_at_fs2, 1);

    // Counter wrap: pin frame_count to 65535 mid-frame, expect 0 at the next frame start.
    wait_pos(300, "wait_force_pos");
    #2;
    force dut.frame_count_q = 16'hFFFF;
    fc_base = 65535 - (n - 1) / FT;
    repeat (2) @(negedge VGA_CLK);
    #2;
    release dut.frame_count_q;
    @(negedge VGA_CLK);
    chk("lit_fc_held", bus.frame_count, 65535);
    wait_pos(0, "wait_wrap_frame");
    chk("lit_fc_wrapped", bus.frame_count, 0);

    // Mid-frame reset while hsync is low at the DAC pins.
    wait_pos(3 * HT + 48, "wait_reset_pos");
    chk("lit_pre_reset_hs", bus.vga_hs, 0);
    #2;
    reset = 1'b1;
    fc_base = 0;
    #1;
    chk("lit_async_hs", bus.vga_hs, 1);
    chk("lit_async_blank", bus.vga_blank_n, 0);
    chk("lit_async_pr", bus.printing, 0);
    chk("lit_async_j", bus.j, 0);
    repeat (3) @(negedge VGA_CLK);
    #2 reset = 1'b0;
    @(negedge VGA_CLK);
    chk("lit_restart_fs", bus.frame_start, 1);
    chk("lit_restart_i", bus.i, 0);
    chk("lit_restart_pr", bus.printing, 1);

    repeat (FT + 20) @(negedge VGA_CLK);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_scan_gen.md
VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in clocks.
REQ-004 Parameter H_BP, default 48, horizontal back porch in clocks; H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
REQ-005 Parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, all in lines; V_TOTAL = 525.
REQ-006 VGA_CLK  in  1  pixel clock (25 MHz nominal); all state on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 rgb_r_in, rgb_g_in, rgb_b_in  in  8 each  pixel colour from consumer, registered by consumer one clock after it sees i/j/printing.
REQ-009 j  out  10  column of requested pixel; i  out  10  row of requested pixel.
REQ-010 printing  out  1  high when (i,j) is inside the visible area.
REQ-011 frame_start  out  1  one-clock pulse at first visible pixel of each frame.
REQ-012 frame_count  out  16  completed-frame counter.
REQ-013 vga_hs, vga_vs  out  1 each  syncs, active-low.
REQ-014 vga_r, vga_g, vga_b  out  8 each  DAC colour.
REQ-015 vga_blank_n  out  1  low during blanking; vga_sync_n  out  1  constant 0.

Function
REQ-016 Free-running h_cnt counts 0..H_TOTAL-1, then wraps to 0.
REQ-017 v_cnt increments when h_cnt wraps; v_cnt counts 0..V_TOTAL-1, then wraps to 0 together with h_cnt.
REQ-018 Stage 0 (registered from counters, 1 clock after counter value): j = h_cnt and i = v_cnt when visible, else both 0; printing = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
REQ-019 frame_start = 1 for exactly the stage-0 cycle where h_cnt = 0 and v_cnt = 0; 0 otherwise.
REQ-020 frame_count increments by 1 (mod 2^16, wrapping 65535->0) in the same cycle as frame_start is asserted, except the first frame after reset.
REQ-021 Raw hsync is active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-022 Raw vsync is active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), across whole lines.
REQ-023 Raw hsync, raw vsync and printing pass through a 2-stage delay to produce vga_hs/vga_vs (inverted) and vga_blank_n.
REQ-024 vga_r/g/b are registered from rgb_*_in in the same cycle, so pixel (i,j) presented at stage 0 appears on the DAC pins at stage 2, aligned with its blank/sync.
REQ-025 vga_r/g/b are forced to 0 whenever the delayed printing is 0, regardless of rgb_*_in.
REQ-026 Pipeline latency, i/j/printing to matching vga_* outputs: exactly 2 clocks, constant, no stalls.

Reset
REQ-027 On reset assertion, immediately (asynchronously): h_cnt = 0, v_cnt = 0, i = 0, j = 0, printing = 0, frame_start = 0, frame_count = 0, vga_hs = 1, vga_vs = 1, vga_blank_n = 0, vga_r/g/b = 0, all delay stages cleared to the blanking/inactive value.
REQ-028 First edge after reset release: stage 0 shows h=0, v=0, printing = 1, frame_start = 1, frame_count stays 0.
REQ-029 Reset asserted mid-frame aborts the frame; no partial sync pulse is extended; restart follows REQ-028.

Verification
REQ-030 Release reset, run 800 clocks -> printing high for 640 consecutive clocks then low for 160; vga_hs low for exactly 96 clocks, starting 658 clocks after the stage-0 cycle of j=0.
REQ-031 Run 2 full frames (2x420000 clocks) -> frame_start pulses exactly 420000 clocks apart; frame_count = 1 after 2nd pulse; vga_vs low for exactly 1600 clocks per frame.
REQ-032 Drive rgb_*_in = {j[7:0], i[7:0], 8'hAA} one clock after i/j -> at each visible DAC cycle, vga_r/g equal j/i of the stage-0 pixel two clocks earlier; during blanking outputs are 0 even with rgb_*_in = 8'hFF.
REQ-033 Assert reset at h=300, v=200 for 3 clocks -> all outputs hold reset values during assertion; after release sequence restarts at h=0, v=0 with frame_start = 1.
REQ-034 Force frame_count to 65535 (or run) then one more frame -> frame_count wraps to 0, no other side effect.
REQ-035 Whole run: check vga_sync_n = 0 always and vga_blank_n = 0 whenever vga_hs or vga_vs is low.
